// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double dabble), optional BCD2BIN_DIGIT_CHECK_EN
module bcd2bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]             state;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BIN_W-1:0]       bin_reg;
    logic [CNT_W-1:0]       cnt;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_sh;
    logic [BCD_W-1:0]       bcd_next;
    logic [BIN_W-1:0]       bin_next;

    // One reverse double dabble step: shift right, then correct every nibble that is 8 or more.
    always_comb begin
        shifted  = {bcd_reg, bin_reg} >> 1;
        bin_next = shifted[BIN_W-1:0];
        bcd_sh   = shifted[BIN_W +: BCD_W];
        bcd_next = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i+3]) begin
                bcd_next[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad_digit;
    logic err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg <= bcd_in;
                        bin_reg <= '0;
                        cnt     <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                        err_q   <= 1'b0;
                        if (bad_digit) begin
                            err_q   <= 1'b1;
                            bin_out <= '0;
                            state   <= FIN;
                        end else begin
                            state   <= CONV;
                        end
`else
                        state   <= CONV;
`endif
                    end
                end
                CONV: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt     <= cnt + 1'b1;
                    // Result is loaded on the last step so it is already valid while done is high.
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bin_out <= bin_next;
                        state   <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CONV);
    assign done = (state == FIN);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed self-checking bench for bcd2bin_seq (defaults plus DIGITS=3 sweep)
module tb_bcd2bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy, done, err;
    logic [6:0] bin_out;

    logic        w_start;
    logic [11:0] w_bcd_in;
    logic        w_busy, w_done, w_err;
    logic [9:0]  w_bin_out;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .bin_out(bin_out)
    );

    bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut_wide (
        .clk(clk), .rst_n(rst_n), .start(w_start), .bcd_in(w_bcd_in),
        .busy(w_busy), .done(w_done), .err(w_err), .bin_out(w_bin_out)
    );

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after the accepting edge; latency counts that edge as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic conv(input logic [7:0] b, input int exp_bin, input int exp_err,
                        input int exp_lat, input string tag);
        int lat;
        start = 1'b1; bcd_in = b;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 8'h66;
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_bin"}, int'(bin_out), exp_bin);
        check({tag, "_err"}, int'(err), exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int d0;
        rst_n = 1'b0; start = 1'b1; bcd_in = 8'h42;
        w_start = 1'b0; w_bcd_in = '0;

        // Reset overrides a start request
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_bin", int'(bin_out), 0);
        start = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_idle_busy", int'(busy), 0);

        conv(8'h42, 42, 0, 8, "c42");
        conv(8'h99, 99, 0, 8, "c99");
        conv(8'h00, 0, 0, 8, "c00");
        conv(8'h10, 10, 0, 8, "c10");

        // Start pulses while busy must not disturb the conversion in flight
        d0 = done_cnt;
        start = 1'b1; bcd_in = 8'h57;
        @(posedge clk); #1;
        start = 1'b0; bcd_in = 8'h13;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b0;
        lat = 6;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("busy_lat", lat, 8);
        check("busy_bin", int'(bin_out), 57);
        start = 1'b1; bcd_in = 8'h13;
        @(posedge clk); #1;
        check("fin_ignored_busy", int'(busy), 0);
        check("single_done", done_cnt - d0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("next_accept_busy", int'(busy), 1);
        wait_done(lat);
        check("c13_lat", lat, 8);
        check("c13_bin", int'(bin_out), 13);
        @(posedge clk); #1;

`ifdef BCD2BIN_DIGIT_CHECK_EN
        conv(8'h1A, 0, 1, 1, "c1a_bad");
        conv(8'h25, 25, 0, 8, "c25_after_bad");
`else
        start = 1'b1; bcd_in = 8'h1A;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check("c1a_nochk_lat", lat, 8);
        check("c1a_nochk_err", int'(err), 0);
        @(posedge clk); #1;
        conv(8'h25, 25, 0, 8, "c25");
`endif

        // Reset mid-conversion discards the result
        d0 = done_cnt;
        start = 1'b1; bcd_in = 8'h88;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_bin", int'(bin_out), 0);
        check("mid_rst_err", int'(err), 0);
        repeat (10) begin @(posedge clk); #1; end
        check("mid_rst_no_done", done_cnt - d0, 0);
        conv(8'h07, 7, 0, 8, "c07");

        // Exhaustive 000..999 on the 3-digit, 10-bit instance
        for (int v = 0; v < 1000; v++) begin
            w_start = 1'b1;
            w_bcd_in = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            @(posedge clk); #1;
            w_start = 1'b0; w_bcd_in = 12'h999;
            lat = 1;
            while (!w_done && lat < 40) begin @(posedge clk); #1; lat++; end
            check($sformatf("sweep_lat_%0d", v), lat, 11);
            check($sformatf("sweep_bin_%0d", v), int'(w_bin_out), v);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double dabble (shift right, then subtract 3 from every BCD nibble that is 8 or more).
It is the decode direction for the team's binary-to-BCD display path: it turns keypad or display BCD values back into binary for the arithmetic units.
A start/busy/done handshake is used, with one bit resolved per clock.

Parameters:
DIGITS, 2, number of BCD digits on bcd_in (1..4).
BIN_W, 7, width of the binary result. Must satisfy 2^BIN_W >= 10^DIGITS. For DIGITS=2 this means 99 fits in 7 bits.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request conversion. Sampled only when busy=0.
bcd_in  input  4*DIGITS  packed BCD. Bits [3:0] are the least significant digit. Captured on the accepted start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bin_out/err are updated.
err  output  1  invalid-digit flag. Valid with done; held until the next accepted start.
bin_out  output  BIN_W  result. Valid with done; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge) is synchronous and active-low. It forces:
  - state=IDLE;
  - busy=0, done=0, err=0, bin_out=0;
  - internal shift register and counter cleared.
- Reset has priority over every other event, including mid-conversion. Any conversion in progress is discarded with no done pulse.
- States: IDLE, CONV, FIN.
- IDLE:
  - start=1 is accepted.
  - {bcd_reg, bin_reg} <= {bcd_in, 0}; cnt <= 0.
  - With a valid input: go to CONV, busy=1.
  - Invalid-digit path (see Optional Feature): go directly to FIN.
- CONV, one step per cycle:
  - {bcd_reg, bin_reg} shifted right by 1 (the bcd_reg LSB enters the bin_reg MSB);
  - then each 4-bit nibble of the shifted bcd_reg that is >= 8 has 3 subtracted;
  - cnt increments.
  - After the step with cnt = BIN_W-1, go to FIN.
- FIN:
  - bin_out <= bin_reg; done=1 for exactly this one cycle; busy=0.
  - Go to IDLE.
  - start in FIN is ignored. The earliest accepted start is in the following IDLE cycle.
- start while busy=1 is ignored and has no effect on the conversion in flight.
- Latency: start accepted at edge N; done high in the cycle after edge N+BIN_W (BIN_W+1 cycles after acceptance).
  - Default parameters give 8 cycles.
  - Throughput is one conversion per BIN_W+2 cycles.
- After BIN_W steps bcd_reg is all zero for any valid input. The bench may assert this internally.
- bcd_in changes after acceptance do not affect the result.
- Arithmetic:
  - Nibble subtract is 4-bit, never underflows (applied only when the nibble is >= 8).
  - No overflow is possible given the BIN_W constraint.

Optional Feature:
Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - At start acceptance, any bcd_in nibble > 9 skips CONV and goes straight to FIN.
  - FIN then pulses done with err=1 and bin_out=0.
  - Latency is 1 cycle.
  - Valid inputs give err=0.
- Not defined:
  - No check is made; every input runs through CONV.
  - err is tied 0.
  - bin_out for invalid nibbles is whatever the algorithm produces and is not checked.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles during a start pulse -> busy=0, done=0, err=0, bin_out=0; no conversion begins.
2. Basic conversions with defaults (DIGITS=2, BIN_W=7), each awaiting done:
   - bcd_in=0x42 -> bin_out=42 (0x2A), err=0, done exactly 8 cycles after the start edge.
   - 0x99 -> 99 (0x63).
   - 0x00 -> 0.
   - 0x10 -> 10.
3. Busy handling: start with 0x57, then pulse start with 0x13 during cycles 2-5 -> single done, bin_out=57. A start in the FIN cycle is ignored; a start on the next cycle with 0x13 yields 13.
4. Invalid digit, with BCD2BIN_DIGIT_CHECK_EN defined: bcd_in=0x1A -> done 1 cycle later, err=1, bin_out=0. A following start with 0x25 -> err=0, bin_out=25.
5. Reset mid-operation: start 0x88, drop rst_n for one cycle at cycle 4 -> no done pulse, outputs 0. A fresh start with 0x07 -> bin_out=7 after 8 cycles.
6. Parameter sweep: DIGITS=3, BIN_W=10, exhaustive 000..999 -> bin_out equals the decimal value, latency 11 cycles each.
